// File: rtl/piso_serializer_pkg.sv
// Shared sequence-detector definitions: FSM encodings and default word width
// used by the serializer and the seq1010 benches.
package piso_serializer_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/piso_serializer.sv
// Parallel-in serial-out serializer feeding the seq1010 detector. Words are
// accepted on load_valid && load_ready and emitted one bit per cycle.
module piso_serializer
    import piso_serializer_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [WIDTH-1:0] din,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             dout,
    output logic             dout_valid,
    output logic             frame_last,
    output logic             state_dbg
);

    // Handshake: a word transfers at a rising edge where load_valid and
    // load_ready are both high; load_ready never depends on load_valid.

    localparam int CNT_W = $clog2(WIDTH);

    state_t           state;
    logic [WIDTH-1:0] sreg;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] sreg_shifted;

    function automatic logic out_bit(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    assign sreg_shifted = MSB_FIRST ? {sreg[WIDTH-2:0], 1'b0}
                                    : {1'b0, sreg[WIDTH-1:1]};

    // Ready in IDLE, or on the last bit of a frame so words chain without gaps.
    assign load_ready = (state == IDLE) || ((state == SHIFT) && (cnt == '0));
    assign state_dbg  = state;

    always_ff @(posedge clk) begin
        if (clr) begin
            state      <= IDLE;
            sreg       <= '0;
            cnt        <= '0;
            dout       <= 1'b0;
            dout_valid <= 1'b0;
            frame_last <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (load_valid) begin
                        state      <= SHIFT;
                        sreg       <= din;
                        cnt        <= CNT_W'(WIDTH - 1);
                        dout       <= out_bit(din);
                        dout_valid <= 1'b1;
                        frame_last <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (cnt != '0) begin
                        sreg       <= sreg_shifted;
                        cnt        <= cnt - 1'b1;
                        dout       <= out_bit(sreg_shifted);
                        dout_valid <= 1'b1;
                        frame_last <= (cnt == CNT_W'(1));
                    end else if (load_valid) begin
                        sreg       <= din;
                        cnt        <= CNT_W'(WIDTH - 1);
                        dout       <= out_bit(din);
                        dout_valid <= 1'b1;
                        frame_last <= 1'b0;
                    end else begin
                        state      <= IDLE;
                        dout       <= 1'b0;
                        dout_valid <= 1'b0;
                        frame_last <= 1'b0;
                    end
                end
                default: begin
                    state      <= IDLE;
                    dout       <= 1'b0;
                    dout_valid <= 1'b0;
                    frame_last <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_piso_serializer.sv
// Self-checking bench for piso_serializer: MSB-first instance checked by a
// scoreboard of expected {frame_last, dout} pairs, plus an LSB-first instance.
module tb_piso_serializer;

    localparam int W = 8;

    logic         clk;
    logic         clr;
    logic [W-1:0] din;
    logic         load_valid;
    logic         load_ready;
    logic         dout;
    logic         dout_valid;
    logic         frame_last;
    logic         state_dbg;

    logic [W-1:0] l_din;
    logic         l_load_valid;
    logic         l_load_ready;
    logic         l_dout;
    logic         l_dout_valid;
    logic         l_frame_last;
    logic         l_state_dbg;

    int checks = 0;
    int errors = 0;
    bit mon_en = 0;
    int run_len = 0;
    int max_run = 0;

    logic [1:0] exp_q[$];

    piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .clr(clr), .din(din), .load_valid(load_valid),
        .load_ready(load_ready), .dout(dout), .dout_valid(dout_valid),
        .frame_last(frame_last), .state_dbg(state_dbg)
    );

    piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .clr(clr), .din(l_din), .load_valid(l_load_valid),
        .load_ready(l_load_ready), .dout(l_dout), .dout_valid(l_dout_valid),
        .frame_last(l_frame_last), .state_dbg(l_state_dbg)
    );

    // Clock / watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    // Scoreboard monitor: every valid bit must match the next expected pair;
    // outside a frame all serial outputs must be 0.
    always @(negedge clk) begin
        if (mon_en) begin
            logic [1:0] e;
            checks++;
            if (dout_valid === 1'b1) begin
                run_len++;
                if (run_len > max_run) max_run = run_len;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_bit: got dout_valid=1 dout=%b, required no valid bit", dout);
                end else begin
                    e = exp_q.pop_front();
                    if ({frame_last, dout} !== e) begin
                        errors++;
                        $display("FAIL serial_bit: got frame_last,dout=%b%b, required %b%b",
                                 frame_last, dout, e[1], e[0]);
                    end
                end
            end else begin
                run_len = 0;
                if (dout_valid !== 1'b0 || dout !== 1'b0 || frame_last !== 1'b0) begin
                    errors++;
                    $display("FAIL idle_outputs: got dv=%b dout=%b fl=%b, required 000",
                             dout_valid, dout, frame_last);
                end
            end
        end
    end

    // Driver: offer a word, wait (bounded) for load_ready, push the expected
    // bit sequence, and return just after the accepting edge.
    task automatic offer(input logic [W-1:0] w, output logic fl_at_accept);
        int n;
        n = 0;
        din = w;
        load_valid = 1'b1;
        while (load_ready !== 1'b1 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (load_ready !== 1'b1) begin
            errors++;
            $display("FAIL offer_timeout: got load_ready=%b, required 1", load_ready);
        end
        fl_at_accept = frame_last;
        for (int i = 0; i < W; i++)
            exp_q.push_back({(i == W - 1) ? 1'b1 : 1'b0, w[W-1-i]});
        @(posedge clk); #1;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((state_dbg !== 1'b0 || exp_q.size() != 0) && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (state_dbg !== 1'b0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_idle: got state=%b pending=%0d, required state=0 pending=0",
                     name, state_dbg, exp_q.size());
        end
    endtask

    task automatic test_reset();
        clr = 1'b1;
        din = 8'hFF;
        load_valid = 1'b1;
        l_din = 8'hFF;
        l_load_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (dout !== 1'b0 || dout_valid !== 1'b0 || frame_last !== 1'b0 || load_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_outputs: got dout=%b dv=%b fl=%b lr=%b, required 0 0 0 1",
                     dout, dout_valid, frame_last, load_ready);
        end
        checks++;
        if (l_dout_valid !== 1'b0 || l_load_ready !== 1'b1 || state_dbg !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got l_dv=%b l_lr=%b state=%b, required 0 1 0",
                     l_dout_valid, l_load_ready, state_dbg);
        end
        clr = 1'b0;
        load_valid = 1'b0;
        l_load_valid = 1'b0;
        mon_en = 1'b1;
    endtask

    task automatic test_single_word();
        logic fl;
        offer(8'hA5, fl);
        load_valid = 1'b0;
        checks++;
        if (dout_valid !== 1'b1 || dout !== 1'b1) begin
            errors++;
            $display("FAIL single_latency: got dv=%b dout=%b, required 1 1", dout_valid, dout);
        end
        repeat (7) @(posedge clk);
        #1;
        checks++;
        if (frame_last !== 1'b1 || load_ready !== 1'b1) begin
            errors++;
            $display("FAIL single_last: got fl=%b lr=%b, required 1 1", frame_last, load_ready);
        end
        @(posedge clk); #1;
        checks++;
        if (state_dbg !== 1'b0 || load_ready !== 1'b1 || dout_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_end: got state=%b lr=%b dv=%b, required 0 1 0",
                     state_dbg, load_ready, dout_valid);
        end
        wait_idle("single");
    endtask

    task automatic test_back_to_back();
        logic fl1, fl2;
        max_run = 0;
        offer(8'h0A, fl1);
        offer(8'hA0, fl2);
        load_valid = 1'b0;
        checks++;
        if (fl2 !== 1'b1) begin
            errors++;
            $display("FAIL b2b_accept_on_last: got frame_last=%b at second accept, required 1", fl2);
        end
        checks++;
        if (fl1 !== 1'b0) begin
            errors++;
            $display("FAIL b2b_first_accept: got frame_last=%b at first accept, required 0", fl1);
        end
        wait_idle("b2b");
        checks++;
        if (max_run != 16) begin
            errors++;
            $display("FAIL b2b_contiguous: got run of %0d valid bits, required 16", max_run);
        end
    endtask

    task automatic test_backpressure();
        logic fl;
        offer(8'hC3, fl);
        load_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        din = 8'h00;
        load_valid = 1'b1;
        checks++;
        if (load_ready !== 1'b0) begin
            errors++;
            $display("FAIL backpressure_ready: got load_ready=%b while cnt=5, required 0", load_ready);
        end
        @(posedge clk); #1;
        load_valid = 1'b0;
        wait_idle("backpressure");
    endtask

    task automatic test_abort();
        logic fl;
        offer(8'hFF, fl);
        load_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        checks++;
        if (dout_valid !== 1'b0 || load_ready !== 1'b1 || dout !== 1'b0) begin
            errors++;
            $display("FAIL abort_outputs: got dv=%b lr=%b dout=%b, required 0 1 0",
                     dout_valid, load_ready, dout);
        end
        checks++;
        if (exp_q.size() != 5) begin
            errors++;
            $display("FAIL abort_consumed: got %0d bits pending, required 5", exp_q.size());
        end
        exp_q.delete();
        repeat (12) @(posedge clk);
        #1;
        wait_idle("abort");
    endtask

    task automatic test_lsb_first();
        logic [W-1:0] w;
        w = 8'h05;
        @(posedge clk); #1;
        l_din = w;
        l_load_valid = 1'b1;
        checks++;
        if (l_load_ready !== 1'b1) begin
            errors++;
            $display("FAIL lsb_ready: got load_ready=%b, required 1", l_load_ready);
        end
        @(posedge clk); #1;
        l_load_valid = 1'b0;
        for (int i = 0; i < W; i++) begin
            checks++;
            if (l_dout_valid !== 1'b1 || l_dout !== w[i] || l_frame_last !== (i == W - 1)) begin
                errors++;
                $display("FAIL lsb_bit%0d: got dv=%b dout=%b fl=%b, required 1 %b %b",
                         i, l_dout_valid, l_dout, l_frame_last, w[i], (i == W - 1));
            end
            @(posedge clk); #1;
        end
        checks++;
        if (l_dout_valid !== 1'b0 || l_load_ready !== 1'b1 || l_state_dbg !== 1'b0) begin
            errors++;
            $display("FAIL lsb_end: got dv=%b lr=%b state=%b, required 0 1 0",
                     l_dout_valid, l_load_ready, l_state_dbg);
        end
    endtask

    task automatic test_random();
        logic fl;
        for (int k = 0; k < 6; k++) begin
            offer(W'($urandom_range(0, 255)), fl);
            load_valid = 1'b0;
            repeat ($urandom_range(0, 10)) @(posedge clk);
            #1;
        end
        wait_idle("random");
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_back_to_back();
        test_backpressure();
        test_abort();
        test_lsb_first();
        test_random();
        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/piso_serializer.md
PISO_SERIALIZER -- requirements
Module: piso_serializer

Interface
REQ-001 Parameter WIDTH, default 8, word length in bits; legal range 2..32.
REQ-002 Parameter MSB_FIRST, default 1; 1 sends MSB first, 0 sends LSB first.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 clr  input  1  reset, synchronous, active-high.
REQ-005 din  input  WIDTH  parallel word to serialize.
REQ-006 load_valid  input  1  producer offers din this cycle.
REQ-007 load_ready  output  1  block accepts din this cycle; transfer occurs when load_valid and load_ready are both high at a rising edge.
REQ-008 dout  output  1  serial bit stream, the d input of the downstream seq1010 detector.
REQ-009 dout_valid  output  1  dout carries a frame bit this cycle.
REQ-010 frame_last  output  1  dout carries the final bit of the current word.

Function
REQ-011 The FSM SHALL have two states: IDLE and SHIFT.
REQ-012 In IDLE, the block SHALL drive load_ready=1, dout=0, dout_valid=0 and frame_last=0.
REQ-013 On a transfer in IDLE, the block SHALL capture din, load bit counter cnt=WIDTH-1 and enter SHIFT.
REQ-014 Latency: the first bit SHALL appear on dout in the cycle following the accepting edge.
REQ-015 In SHIFT, dout SHALL equal the shift-register MSB (or LSB if MSB_FIRST=0); dout_valid=1.
REQ-016 At each edge in SHIFT with cnt!=0, the block SHALL shift by one position toward the output end and decrement cnt.
REQ-017 frame_last SHALL be 1 exactly when state=SHIFT and cnt=0.
REQ-018 load_ready SHALL be combinational: high in IDLE, or in SHIFT with cnt=0; low otherwise.
REQ-019 In SHIFT with cnt=0 and a transfer at the edge, the block SHALL load the new word, reload cnt=WIDTH-1 and remain in SHIFT. Consecutive words SHALL be sent with zero bubble cycles.
REQ-020 In SHIFT with cnt=0 and no transfer, the block SHALL return to IDLE.
REQ-021 The block SHALL ignore din and load_valid whenever load_ready=0; no state change.
REQ-022 cnt SHALL be $clog2(WIDTH) bits wide and SHALL never wrap below 0.
REQ-023 Each accepted word SHALL emit exactly WIDTH valid bits, in order, with none dropped or duplicated.

Reset
REQ-024 When clr=1 at an edge, the next state SHALL be IDLE, with shift register=0 and cnt=0; outputs then read dout=0, dout_valid=0, frame_last=0, load_ready=1.
REQ-025 clr SHALL take priority over a simultaneous transfer; that word is not accepted.
REQ-026 clr asserted mid-frame SHALL abort the frame; the remaining bits are discarded and not resumed.
REQ-027 The block SHALL never hold any output X after the first clr edge.

Structure
REQ-028 State encodings (IDLE=0, SHIFT=1) and the default WIDTH constant SHALL reside in the shared sequence-detector package/include, used by this block and seq1010 benches.
REQ-029 The design SHALL be a single module with no sub-modules; the shift register, counter and FSM are inline.
REQ-030 dout, dout_valid and frame_last SHALL be register-derived; load_ready is the only combinational output.

Verification
REQ-031 Reset: clr=1 for 2 cycles with load_valid=1 -> no transfer; dout=0, dout_valid=0, load_ready=1.
REQ-032 Single word: din=8'hA5, MSB_FIRST=1, one-cycle load_valid -> dout=1,0,1,0,0,1,0,1 on the 8 cycles after acceptance; frame_last only on the 8th; then IDLE.
REQ-033 Back-to-back: 8'h0A then 8'hA0, load_valid held -> 16 contiguous valid bits 0000101010100000, no gap; second accept coincides with frame_last of the first word.
REQ-034 Abort: clr=1 while 3rd bit of 8'hFF is on dout -> next cycle dout_valid=0, load_ready=1; no further 1s.
REQ-035 LSB-first: MSB_FIRST=0, din=8'h05 -> dout=1,0,1,0,0,0,0,0.
REQ-036 Backpressure: load_valid pulses with din=8'h00 while cnt=5 -> load_ready=0, ignored; current frame unchanged.
